// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet TX constants, CRC polynomial and TX state type (IFG state under MAC_TX_IFG_EN)
package eth_pkg;

   localparam int          eth_preamble_length       = 7;
   localparam logic [7:0]  eth_preamble_byte         = 8'h55;
   localparam logic [7:0]  eth_sfd_byte              = 8'hD5;
   localparam int          eth_fcs_length            = 4;
   localparam int          eth_min_frame_size        = 64;
   localparam int          eth_mac_header_length     = 14;
   localparam int          eth_tx_header_byte_length = 16;
   localparam int          eth_tx_header_addr_width  = 2;
   localparam logic [31:0] eth_crc32_poly            = 32'hEDB88320;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PAD,
`ifdef MAC_TX_IFG_EN
      ST_FCS,
      ST_IFG
`else
      ST_FCS
`endif
   } mac_tx_state_t;

endpackage

// File: rtl/eth_crc32_8.sv
// rtl/eth_crc32_8.sv - combinational byte-wise reflected CRC-32 update
module eth_crc32_8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   // Fold the byte into the low end, then shift out eight bits LSB first
   always_comb begin
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ eth_crc32_poly) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/mac_tx_multi_hdr.sv
// rtl/mac_tx_multi_hdr.sv - byte-wide MAC transmitter with selectable header slots; MAC_TX_IFG_EN adds the inter-frame gap
module mac_tx_multi_hdr
   import eth_pkg::*;
#(
   parameter int NUM_HEADERS     = 4,
   parameter int HEADER_BYTES    = eth_mac_header_length,
   parameter int MIN_FRAME_BYTES = eth_min_frame_size,
   parameter int IFG_CYCLES      = 12
) (
   input  logic                                                    Clk,
   input  logic                                                    Rst,
   input  logic                                                    Header_wr_en,
   input  logic [((NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1)-1:0] Header_wr_index,
   input  logic [eth_tx_header_addr_width-1:0]                      Header_wr_addr,
   input  logic [31:0]                                             Header_wr_data,
   input  logic                                                    Payload_valid,
   output logic                                                    Payload_ready,
   input  logic [7:0]                                              Payload_data,
   input  logic                                                    Payload_last,
   input  logic [((NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1)-1:0] Payload_header_sel,
   output logic                                                    Mac_valid,
   input  logic                                                    Mac_ready,
   output logic [7:0]                                              Mac_data,
   output logic                                                    Mac_last
);

   localparam int          SEL_W      = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;
   localparam int          AW         = eth_tx_header_addr_width;
   localparam int          DEPTH      = NUM_HEADERS * (2 ** AW);
   localparam logic [15:0] PAD_TARGET = 16'(MIN_FRAME_BYTES - eth_fcs_length);
   localparam logic [7:0]  HDR_LAST   = 8'(HEADER_BYTES - 1);
   localparam logic [2:0]  PRE_LAST   = 3'(eth_preamble_length - 1);

   mac_tx_state_t    state;
   logic [2:0]       pre_cnt;
   logic [7:0]       hdr_idx;
   logic [7:0]       hdr_next;
   logic [2:0]       fcs_idx;
   logic [15:0]      byte_cnt;
   logic [15:0]      cnt_inc;
   logic [31:0]      crc;
   logic [31:0]      crc_next;
   logic [31:0]      crc_fin;
   logic [7:0]       crc_din;
   logic [SEL_W-1:0] sel;
   logic             adv;
   logic [AW-1:0]    rd_word;
   logic [31:0]      rd_q;
   logic [7:0]       hdr_byte;
   logic [7:0]       fcs_byte;
   logic [31:0]      ram [DEPTH];

`ifdef MAC_TX_IFG_EN
   localparam int            IFG_W    = $clog2(IFG_CYCLES + 1);
   localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
   logic [IFG_W-1:0] ifg_cnt;
`endif

   // Output-register advance, payload handshake and per-byte datapath selects
   always_comb begin
      adv           = !Mac_valid || Mac_ready;
      Payload_ready = (state == ST_PAYLOAD) && adv;
      hdr_next      = hdr_idx + 8'd1;
      // Look one byte ahead when the current header byte leaves this cycle so HEADER never bubbles
      rd_word       = (state == ST_HEADER && adv) ? hdr_next[AW+1:2] : hdr_idx[AW+1:2];
      hdr_byte      = rd_q[{hdr_idx[1:0], 3'b000} +: 8];
      cnt_inc       = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
      crc_fin       = ~crc;
      fcs_byte      = crc_fin[{fcs_idx[1:0], 3'b000} +: 8];
      case (state)
         ST_HEADER:  crc_din = hdr_byte;
         ST_PAYLOAD: crc_din = Payload_data;
         default:    crc_din = 8'h00;
      endcase
   end

   eth_crc32_8 u_crc (
      .crc_in  (crc),
      .data    (crc_din),
      .crc_out (crc_next)
   );

   // Header RAM: one write port, registered read port (not touched by reset)
   always_ff @(posedge Clk) begin
      if (Header_wr_en) begin
         ram[{Header_wr_index, Header_wr_addr}] <= Header_wr_data;
      end
      rd_q <= ram[{sel, rd_word}];
   end

   // Frame sequencer with the output register; every byte loads only on adv
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= ST_IDLE;
         Mac_valid <= 1'b0;
         Mac_last <= 1'b0;
         Mac_data <= 8'h00;
         pre_cnt  <= '0;
         hdr_idx  <= '0;
         fcs_idx  <= '0;
         byte_cnt <= '0;
         crc      <= 32'hFFFF_FFFF;
         sel      <= '0;
`ifdef MAC_TX_IFG_EN
         ifg_cnt  <= '0;
`endif
      end else begin
         if (adv) begin
            Mac_valid <= 1'b0;
            Mac_last  <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (Payload_valid) begin
                  sel      <= Payload_header_sel;
                  pre_cnt  <= '0;
                  hdr_idx  <= '0;
                  fcs_idx  <= '0;
                  byte_cnt <= '0;
                  crc      <= 32'hFFFF_FFFF;
                  state    <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: if (adv) begin
               Mac_valid <= 1'b1;
               Mac_data  <= eth_preamble_byte;
               pre_cnt   <= pre_cnt + 3'd1;
               if (pre_cnt == PRE_LAST) state <= ST_SFD;
            end
            ST_SFD: if (adv) begin
               Mac_valid <= 1'b1;
               Mac_data  <= eth_sfd_byte;
               state     <= (HEADER_BYTES == 0) ? ST_PAYLOAD : ST_HEADER;
            end
            ST_HEADER: if (adv) begin
               Mac_valid <= 1'b1;
               Mac_data  <= hdr_byte;
               crc       <= crc_next;
               byte_cnt  <= cnt_inc;
               hdr_idx   <= hdr_next;
               if (hdr_idx == HDR_LAST) state <= ST_PAYLOAD;
            end
            ST_PAYLOAD: if (adv && Payload_valid) begin
               Mac_valid <= 1'b1;
               Mac_data  <= Payload_data;
               crc       <= crc_next;
               byte_cnt  <= cnt_inc;
               if (Payload_last) state <= (cnt_inc < PAD_TARGET) ? ST_PAD : ST_FCS;
            end
            ST_PAD: if (adv) begin
               Mac_valid <= 1'b1;
               Mac_data  <= 8'h00;
               crc       <= crc_next;
               byte_cnt  <= cnt_inc;
               if (cnt_inc >= PAD_TARGET) state <= ST_FCS;
            end
`ifdef MAC_TX_IFG_EN
            // fcs_idx==4 means the last byte is waiting for its handshake
            ST_FCS: if (adv) begin
               if (fcs_idx == 3'd4) begin
                  ifg_cnt <= '0;
                  state   <= ST_IFG;
               end else begin
                  Mac_valid <= 1'b1;
                  Mac_data  <= fcs_byte;
                  Mac_last  <= (fcs_idx == 3'd3);
                  fcs_idx   <= fcs_idx + 3'd1;
               end
            end
            ST_IFG: begin
               ifg_cnt <= ifg_cnt + 1'b1;
               if (ifg_cnt == IFG_LAST) state <= ST_IDLE;
            end
`else
            ST_FCS: if (adv) begin
               Mac_valid <= 1'b1;
               Mac_data  <= fcs_byte;
               Mac_last  <= (fcs_idx == 3'd3);
               fcs_idx   <= fcs_idx + 3'd1;
               if (fcs_idx == 3'd3) state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mac_tx_multi_hdr.md
# mac_tx_multi_hdr

Parametrised successor to the 1G Ethernet MAC transmitter. It holds `NUM_HEADERS` pre-loaded header slots and selects one per frame. Each frame is built as preamble, SFD, the selected header, the streamed payload, zero padding to the minimum frame size and the CRC-32 FCS, and is emitted as a byte-wide AXI-style stream. The block sits between the packet builder (payload stream plus header select) and the PHY-side byte interface.

## Interface
Parameters:
- `NUM_HEADERS`, 4: number of header slots; power of two, ≥1.
- `HEADER_BYTES`, `eth_mac_header_length`: header bytes emitted per frame, read from the start of the slot; ≤ `eth_tx_header_byte_length`.
- `MIN_FRAME_BYTES`, `eth_min_frame_size`: minimum frame size, FCS included.
- `IFG_CYCLES`, 12: idle gap after each frame; used only with `MAC_TX_IFG_EN`.

Ports:
- `Clk` in 1: the single clock.
- `Rst` in 1: synchronous, active-high reset.
- `Header_wr_en` in 1: header RAM write strobe.
- `Header_wr_index` in `$clog2(NUM_HEADERS)` (min 1): slot being written.
- `Header_wr_addr` in `eth_tx_header_addr_width`: 32-bit word index within the slot.
- `Header_wr_data` in 32: header word; byte *n* of the word sits at bits `[8n+7:8n]`.
- `Payload_valid` in 1: payload beat valid.
- `Payload_ready` out 1: payload beat accepted when high together with `Payload_valid`.
- `Payload_data` in 8: payload byte.
- `Payload_last` in 1: marks the final payload byte.
- `Payload_header_sel` in `$clog2(NUM_HEADERS)`: header slot for the frame; sampled on the first beat only.
- `Mac_valid` out 1: output byte valid.
- `Mac_ready` in 1: sink accepts the output byte.
- `Mac_data` out 8: frame byte.
- `Mac_last` out 1: marks the final FCS byte.

## Operation
- **Output register.** A single output register advances when `!Mac_valid || Mac_ready` (called "adv"). While `Mac_valid` is high and `Mac_ready` is low, `Mac_data` and `Mac_last` hold.
- **State machine:** IDLE → PREAMBLE → SFD → HEADER → PAYLOAD → PAD → FCS → (IFG) → IDLE.
  - IDLE: on `Payload_valid`, latch `Payload_header_sel` and go to PREAMBLE. The payload beat is not consumed.
  - PREAMBLE: emit `eth_preamble_length` bytes of `eth_preamble_byte`.
  - SFD: emit `eth_sfd_byte`.
  - HEADER: emit `HEADER_BYTES` bytes from the latched slot, byte order 0..N-1.
  - PAYLOAD: `Payload_ready = (state==PAYLOAD) && adv`. This is a combinational path from `Mac_ready`. Each accepted byte is emitted. An accepted byte with `Payload_last` high goes to PAD if the byte count (header+payload) is below `MIN_FRAME_BYTES - eth_fcs_length`, otherwise to FCS.
  - PAD: emit 0x00 until the byte count reaches `MIN_FRAME_BYTES - eth_fcs_length`.
  - FCS: emit 4 bytes, LSB first, with `Mac_last` on the 4th.
- **CRC.** Reflected CRC-32, polynomial 0xEDB88320, initial value all-ones, final XOR 0xFFFFFFFF. Coverage: header, payload and pad bytes; preamble and SFD excluded. The CRC is updated only when a byte enters the output register.
- **Byte counter.** 16-bit, saturating; frames up to 65535 bytes.
- **Header writes.**
  - Writes are accepted in every state, including mid-frame.
  - A header byte already emitted is unaffected by a later write.
  - Header bytes not yet emitted use the RAM content at the time they are read.
- **Reset.**
  - `Rst` returns the FSM to IDLE and clears the CRC and counters.
  - Reset output values: `Mac_valid`=0, `Mac_last`=0, `Payload_ready`=0.
  - A frame interrupted mid-way is dropped, with no `Mac_last`.
  - Header RAM is not cleared.

## Timing
- The first preamble byte is valid 2 cycles after `Payload_valid` rises in IDLE: 1 cycle for the IDLE→PREAMBLE transition, 1 cycle for the output register.
- With `Mac_ready` held high the output is 1 byte per cycle, with no bubbles across state boundaries. The exception is payload underflow: a PAYLOAD cycle with `Payload_valid` low produces `Mac_valid` low.
- Header RAM has 1-cycle read latency. The read address is prefetched in SFD so HEADER has no bubble.
- Back-to-back frames without the IFG: the next frame's first preamble byte may follow the cycle after the `Mac_last` handshake.

## Configuration
- `MAC_TX_IFG_EN` defined:
  - After the `Mac_last` handshake, the FSM enters IFG for `IFG_CYCLES` cycles with `Mac_valid`=0 and `Payload_ready`=0, then returns to IDLE.
  - `Rst` during IFG exits immediately to IDLE.
- `MAC_TX_IFG_EN` undefined: the IFG state and its counter are absent, and FCS goes directly to IDLE.

## Structure
- Package `eth_pkg` holds:
  - existing constants: `eth_preamble_length`, `eth_preamble_byte`, `eth_sfd_byte`, `eth_fcs_length`, `eth_min_frame_size`, `eth_mac_header_length`, `eth_tx_header_byte_length`, `eth_tx_header_addr_width`;
  - new additions: `eth_crc32_poly` and the state enum `mac_tx_state_t`.
- Sub-module `eth_crc32_8`: a combinational byte-wise CRC-32 update (crc_in, byte → crc_out), reusable by the RX path.
- Header RAM: inferred, `NUM_HEADERS * 2**eth_tx_header_addr_width` words of 32 bits, one write port and one read port.

## Test plan
- Slot 0 loaded with a random header, 1-byte payload, `Mac_ready`=1 → 7×0x55, 0xD5, 14 header bytes, 1 payload byte, 45×0x00, 4 FCS bytes matching the software CRC (72 bytes total).
- Slots 0–3 with distinct headers; 4 frames of 100 bytes with `Payload_header_sel`=3,0,2,1 → each frame carries the selected header and a correct FCS.
- Payloads of 45, 46 and 1500 bytes → pad of 1, 0 and 0 bytes respectively; byte counts 72, 72, 1526.
- `Mac_ready` random at 80 % and `Payload_valid` random at 90 % over 200 frames → byte-exact match and FCS match; no byte lost or duplicated.
- `Rst` pulsed during PAYLOAD of frame 1, then frame 2 sent → `Mac_valid`=0 the cycle after reset, no `Mac_last` for frame 1, frame 2 correct.
- With `MAC_TX_IFG_EN`, two back-to-back 60-byte frames → exactly 12 cycles of `Mac_valid`=0 between the `Mac_last` handshake and the first preamble byte of the next frame, plus the 2-cycle start latency.
